// File: rtl/ro_scan_sequencer.sv
// Readout scan sequencer: walks every {region, addr} pair, holds the address
// for SETTLE cycles, captures rdata_i and hands it downstream on a
// valid/ready beat.
module ro_scan_sequencer #(
  parameter int unsigned NUM_REGION = 17,
  parameter int unsigned NUM_ADDR   = 10,
  parameter int unsigned SETTLE     = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic        cont_i,
  input  logic        abort_i,
  output logic [4:0]  region_sel_o,
  output logic [4:0]  addr_o,
  input  logic [23:0] rdata_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [23:0] m_data_o,
  output logic [9:0]  m_tag_o,
  output logic        m_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] scan_cnt_o
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned TAG_W  = 2 * IDX_W;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SET_W  = 4;

  localparam logic [IDX_W-1:0] LAST_REGION = IDX_W'(NUM_REGION - 1);
  localparam logic [IDX_W-1:0] LAST_ADDR   = IDX_W'(NUM_ADDR - 1);
  // WAIT cycles remaining after the first one; SETUP itself is the first held cycle
  localparam logic [SET_W-1:0] WAIT_INIT   = (SETTLE > 1) ? SET_W'(SETTLE - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_PUSH
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   region_q, region_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic               capture;

  // Next-state, address walk, capture and abort handling
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    region_d   = region_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    data_d     = data_q;
    tag_d      = tag_q;
    last_d     = last_q;
    done_d     = 1'b0;
    scan_cnt_d = scan_cnt_q;
    capture    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d  = S_SETUP;
          region_d = '0;
          addr_d   = '0;
        end
      end
      S_SETUP: begin
        if (SETTLE <= 1) begin
          capture = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - SET_W'(1);
        end
      end
      S_PUSH: begin
        if (m_ready_i) begin
          valid_d = 1'b0;
          if (last_q) begin
            done_d     = 1'b1;
            scan_cnt_d = (scan_cnt_q == '1) ? scan_cnt_q : scan_cnt_q + CNT_W'(1);
            region_d   = '0;
            addr_d     = '0;
            state_d    = cont_i ? S_SETUP : S_IDLE;
          end else begin
            state_d = S_SETUP;
            if (addr_q == LAST_ADDR) begin
              addr_d   = '0;
              region_d = region_q + IDX_W'(1);
            end else begin
              addr_d = addr_q + IDX_W'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      state_d = S_PUSH;
      valid_d = 1'b1;
      data_d  = rdata_i;
      tag_d   = {region_q, addr_q};
      last_d  = (region_q == LAST_REGION) && (addr_q == LAST_ADDR);
    end

    // Abort wins over everything, including a same-cycle handshake
    if (abort_i && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      scan_cnt_d = scan_cnt_q;
      region_d   = '0;
      addr_d     = '0;
      cnt_d      = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      region_q   <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      tag_q      <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      scan_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      region_q   <= region_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign region_sel_o = region_q;
  assign addr_o       = addr_q;
  assign m_valid_o    = valid_q;
  assign m_data_o     = data_q;
  assign m_tag_o      = tag_q;
  assign m_last_o     = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign scan_cnt_o   = scan_cnt_q;

endmodule

// File: tb/tb_ro_scan_sequencer.sv
// Directed bench for ro_scan_sequencer with default parameters.
module tb_ro_scan_sequencer;

  localparam int NR    = 17;
  localparam int NA    = 10;
  localparam int ST    = 2;
  localparam int TOTAL = NR * NA;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start_i = 1'b0;
  logic        cont_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        m_ready_i = 1'b1;
  logic [4:0]  region_sel_o;
  logic [4:0]  addr_o;
  logic [23:0] rdata_i;
  logic        m_valid_o;
  logic [23:0] m_data_o;
  logic [9:0]  m_tag_o;
  logic        m_last_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] scan_cnt_o;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  ro_scan_sequencer #(.NUM_REGION(NR), .NUM_ADDR(NA), .SETTLE(ST)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start_i),
    .cont_i       (cont_i),
    .abort_i      (abort_i),
    .region_sel_o (region_sel_o),
    .addr_o       (addr_o),
    .rdata_i      (rdata_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_tag_o      (m_tag_o),
    .m_last_o     (m_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .scan_cnt_o   (scan_cnt_o)
  );

  always #5 clk = ~clk;

  // Bench-defined readout pattern, unique per {region, addr}
  function automatic logic [23:0] mkdata(input logic [9:0] t);
    return {t, ~t, t[3:0]} ^ 24'h3C5A96;
  endfunction

  assign rdata_i = mkdata({region_sel_o, addr_o});

  function automatic logic [9:0] idx2tag(input int idx);
    logic [4:0] r;
    logic [4:0] a;
    r = 5'(idx / NA);
    a = 5'(idx % NA);
    return {r, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied between clock edges, outputs checked before any edge
  task automatic do_reset();
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_busy",   32'(busy_o), 32'(0));
    chk("rst_valid",  32'(m_valid_o), 32'(0));
    chk("rst_last",   32'(m_last_o), 32'(0));
    chk("rst_done",   32'(done_o), 32'(0));
    chk("rst_region", 32'(region_sel_o), 32'(0));
    chk("rst_addr",   32'(addr_o), 32'(0));
    chk("rst_data",   32'(m_data_o), 32'(0));
    chk("rst_tag",    32'(m_tag_o), 32'(0));
    chk("rst_cnt",    32'(scan_cnt_o), 32'(0));
    exp_cnt = 0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic start_scan();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_busy",  32'(busy_o), 32'(1));
    chk("start_sel",   32'({region_sel_o, addr_o}), 32'(0));
    chk("start_valid", 32'(m_valid_o), 32'(0));
  endtask

  // Consume n beats from tag 0 onwards; nscans scans chained via cont_i
  task automatic collect(input int n, input int nscans, input bit bp_en, input bit poke);
    int cyc;
    int idx;
    int scans;
    logic [9:0] et;
    bit last;
    scans = 0;
    for (int i = 0; i < n; i++) begin
      idx  = i % TOTAL;
      et   = idx2tag(idx);
      last = (idx == TOTAL - 1);
      cyc  = 0;
      while (!m_valid_o && cyc < 20) begin
        tick();
        cyc++;
      end
      chk("beat_valid", 32'(m_valid_o), 32'(1));
      if (i > 0) chk("beat_gap", 32'(cyc), 32'(ST));
      chk("tag",       32'(m_tag_o), 32'(et));
      chk("data",      32'(m_data_o), 32'(mkdata(et)));
      chk("last",      32'(m_last_o), 32'(last));
      chk("addr_hold", 32'({region_sel_o, addr_o}), 32'(et));
      if (bp_en && et == 10'h043) begin
        m_ready_i = 1'b0;
        repeat (7) begin
          tick();
          chk("bp_valid", 32'(m_valid_o), 32'(1));
          chk("bp_data",  32'(m_data_o), 32'(mkdata(et)));
          chk("bp_tag",   32'(m_tag_o), 32'(et));
          chk("bp_addr",  32'(addr_o), 32'(et[4:0]));
        end
        m_ready_i = 1'b1;
      end
      if (poke) start_i = 1'b1;
      if (last) begin
        scans++;
        cont_i = (scans < nscans);
      end
      tick();
      start_i = 1'b0;
      chk("valid_drop", 32'(m_valid_o), 32'(0));
      if (last) begin
        exp_cnt++;
        chk("done",      32'(done_o), 32'(1));
        chk("scan_cnt",  32'(scan_cnt_o), 32'(exp_cnt));
        chk("busy_end",  32'(busy_o), 32'(cont_i));
        chk("wrap_sel",  32'({region_sel_o, addr_o}), 32'(0));
      end else begin
        chk("done_low",  32'(done_o), 32'(0));
        chk("busy",      32'(busy_o), 32'(1));
      end
      cont_i = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    do_reset();

    // start together with abort in idle stays idle
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("sa_busy", 32'(busy_o), 32'(0));
    tick();
    chk("sa_valid", 32'(m_valid_o), 32'(0));

    // single full scan, exact first-beat timing, start pokes while busy
    start_scan();
    tick();
    chk("first_c2_valid", 32'(m_valid_o), 32'(0));
    tick();
    chk("first_c3_valid", 32'(m_valid_o), 32'(1));
    chk("first_c3_tag",   32'(m_tag_o), 32'(0));
    collect(TOTAL, 1, 1'b0, 1'b1);
    tick();
    chk("done_pulse_end", 32'(done_o), 32'(0));
    chk("idle_busy",      32'(busy_o), 32'(0));

    // reset asserted while in WAIT of a second scan
    start_scan();
    collect(5, 1, 1'b0, 1'b0);
    tick();
    do_reset();
    tick();
    chk("post_rst_busy",  32'(busy_o), 32'(0));
    chk("post_rst_valid", 32'(m_valid_o), 32'(0));

    // full scan with backpressure on 0x043
    start_scan();
    collect(TOTAL, 1, 1'b1, 1'b0);

    // abort while 0x085 is pending and not accepted
    start_scan();
    collect(45, 1, 1'b0, 1'b0);
    cyc = 0;
    while (!m_valid_o && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("ab_tag", 32'(m_tag_o), 32'(10'h085));
    m_ready_i = 1'b0;
    tick();
    chk("ab_hold", 32'(m_valid_o), 32'(1));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    m_ready_i = 1'b1;
    chk("ab_valid", 32'(m_valid_o), 32'(0));
    chk("ab_busy",  32'(busy_o), 32'(0));
    chk("ab_done",  32'(done_o), 32'(0));
    chk("ab_cnt",   32'(scan_cnt_o), 32'(exp_cnt));
    start_scan();
    tick();
    tick();
    chk("ab_restart_valid", 32'(m_valid_o), 32'(1));
    chk("ab_restart_tag",   32'(m_tag_o), 32'(0));

    // continuous mode for three back-to-back scans
    do_reset();
    start_scan();
    collect(3 * TOTAL, 3, 1'b0, 1'b0);
    tick();
    chk("cont_end_busy", 32'(busy_o), 32'(0));
    chk("cont_end_done", 32'(done_o), 32'(0));
    chk("cont_end_cnt",  32'(scan_cnt_o), 32'(3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
